xor_combine_pipe: RTL

XOR_COMBINE_PIPE -- requirements
Module: xor_combine_pipe

---
 rtl/xor_combine_pipe.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/xor_combine_pipe.sv
// xor_combine_pipe
// Masked multi-lane XOR (optionally XNOR) reduction behind a DEPTH-stage
// valid/ready pipeline. Each stage can fill whenever it is empty, so bubbles
// close up under back-pressure. A saturating counter tallies delivered
// nonzero results.
//
// Stage layout:
//   DEPTH == 1 : the reduction is computed from the live inputs straight into
//                the single (output) stage.
//   DEPTH >= 2 : stage 1 holds the masked lanes plus the invert flag. The
//                reduction sits between stage 1 and stage 2. Stages
//                3..DEPTH carry the reduced word unchanged.
// Only the valid bits, the counter and the output valid are reset.
// data_o is forced to zero while valid_o is low, so payload registers do not
// need a reset.
module xor_combine_pipe #(
    parameter int WIDTH = 1,
    parameter int LANES = 3,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [LANES*WIDTH-1:0] data_i,
    input  logic [LANES-1:0]       mask_i,
    input  logic                   invert_i,
    input  logic                   valid_i,
    output logic                   ready_o,
    output logic [WIDTH-1:0]       data_o,
    output logic                   valid_o,
    input  logic                   ready_i,
    input  logic                   clr_i,
    output logic [CNT_W-1:0]       nz_cnt_o
);

    // XOR of all lanes, seeded with the replicated invert flag. Starting from
    // all-ones gives the XNOR form at no extra cost.
    function automatic logic [WIDTH-1:0] xor_reduce(
        input logic [LANES*WIDTH-1:0] lanes,
        input logic                   inv
    );
        logic [WIDTH-1:0] acc;
        acc = {WIDTH{inv}};
        for (int k = 0; k < LANES; k++) begin
            acc = acc ^ lanes[k*WIDTH +: WIDTH];
        end
        return acc;
    endfunction

    // Lanes whose mask bit is 0 are replaced by zeros before capture.
    logic [LANES*WIDTH-1:0] masked_lanes;

    for (genvar gi = 0; gi < LANES; gi++) begin : g_mask
        assign masked_lanes[gi*WIDTH +: WIDTH] =
            data_i[gi*WIDTH +: WIDTH] & {WIDTH{mask_i[gi]}};
    end

    // ------------------------------------------------------------------
    // Valid chain and advance conditions
    // ------------------------------------------------------------------
    logic [DEPTH-1:0] vld_q;
    logic [DEPTH-1:0] vld_d;
    logic [DEPTH-1:0] adv;

    // A stage may take new contents when it is empty or its successor moves.
    // The last stage moves when the output is idle or the consumer accepts it.
    always_comb begin
        adv            = '0;
        adv[DEPTH-1]   = ~vld_q[DEPTH-1] | ready_i;
        for (int i = DEPTH - 2; i >= 0; i--) begin
            adv[i] = ~vld_q[i] | adv[i+1];
        end
    end

    // Valid bits shift along with their payload. A bubble moving forward
    // loads a 0, so no phantom beat is ever created.
    always_comb begin
        vld_d    = vld_q;
        vld_d[0] = adv[0] ? valid_i : vld_q[0];
        for (int i = 1; i < DEPTH; i++) begin
            vld_d[i] = adv[i] ? vld_q[i-1] : vld_q[i];
        end
    end

    // Valid bits clear asynchronously, so in-flight beats vanish on reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_q <= '0;
        end else begin
            vld_q <= vld_d;
        end
    end

    // ------------------------------------------------------------------
    // Payload path
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] last_data;

    if (DEPTH == 1) begin : g_single
        logic [WIDTH-1:0] out_q;
        logic [WIDTH-1:0] out_d;

        // Single stage: reduce the live inputs directly into the output register.
        always_comb begin
            out_d = out_q;
            if (adv[0]) begin
                out_d = xor_reduce(masked_lanes, invert_i);
            end
        end

        // Payload register, no reset needed (output is gated by valid).
        always_ff @(posedge clk_i) begin
            out_q <= out_d;
        end

        assign last_data = out_q;
    end else begin : g_multi
        logic [LANES*WIDTH-1:0] lanes_q;
        logic [LANES*WIDTH-1:0] lanes_d;
        logic                   inv_q;
        logic                   inv_d;
        logic [WIDTH-1:0]       res_q [1:DEPTH-1];
        logic [WIDTH-1:0]       res_d [1:DEPTH-1];

        // Stage 1 captures masked lanes and invert. Stage 2 captures the
        // reduction. Later stages forward the reduced word.
        always_comb begin
            lanes_d = lanes_q;
            inv_d   = inv_q;
            res_d   = res_q;
            if (adv[0]) begin
                lanes_d = masked_lanes;
                inv_d   = invert_i;
            end
            if (adv[1]) begin
                res_d[1] = xor_reduce(lanes_q, inv_q);
            end
            for (int i = 2; i < DEPTH; i++) begin
                if (adv[i]) begin
                    res_d[i] = res_q[i-1];
                end
            end
        end

        // Payload registers, no reset needed (output is gated by valid).
        always_ff @(posedge clk_i) begin
            lanes_q <= lanes_d;
            inv_q   <= inv_d;
            res_q   <= res_d;
        end

        assign last_data = res_q[DEPTH-1];
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign ready_o = adv[0];
    assign valid_o = vld_q[DEPTH-1];
    assign data_o  = valid_o ? last_data : '0;

    // ------------------------------------------------------------------
    // Nonzero-result counter
    // ------------------------------------------------------------------
    logic             out_fire;
    logic [CNT_W-1:0] nz_cnt_q;
    logic [CNT_W-1:0] nz_cnt_d;

    assign out_fire = valid_o & ready_i;

    // Count delivered nonzero words and saturate at all-ones.
    // A clear wins over a same-cycle increment.
    always_comb begin
        nz_cnt_d = nz_cnt_q;
        if (clr_i) begin
            nz_cnt_d = '0;
        end else if (out_fire && (data_o != '0) && (nz_cnt_q != '1)) begin
            nz_cnt_d = nz_cnt_q + CNT_W'(1);
        end
    end

    // Counter register with asynchronous clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            nz_cnt_q <= '0;
        end else begin
            nz_cnt_q <= nz_cnt_d;
        end
    end

    assign nz_cnt_o = nz_cnt_q;

endmodule
